// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port DMEM arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    localparam int WAIT_CNT_W = 8;

    // Strobes are zero-extended to this width so one helper serves any DATA_WIDTH up to 1024.
    localparam int STRB_MAX_W = 128;

    function automatic logic strb_is_write(input logic [STRB_MAX_W-1:0] strb);
        return |strb;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  req0,    req1;
    logic [ADDR_WIDTH-1:0] addr0,   addr1;
    logic [DATA_WIDTH-1:0] wdata0,  wdata1;
    logic [STRB_W-1:0]     wstrb0,  wstrb1;
    logic                  gnt0,    gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0,  rdata1;
    logic                  mem_en;
    logic [STRB_W-1:0]     mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, wstrb0, wstrb1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_en, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive lost arbitration cycles of the debug port; force1 hands it the next grant.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req1,
    input  logic gnt1,
    output logic force1
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || gnt1) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force1 = (wait_cnt_q == WAIT_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/debug arbiter for a single-port DMEM with 1-cycle read latency.
// Optional grant/conflict counters are built when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DMEM_ARB_PERF_CNT_EN
    output logic [31:0] perf_gnt0,
    output logic [31:0] perf_gnt1,
    output logic [31:0] perf_conflict,
`endif
    dmem_arbiter_if.slave bus
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic                  force1;
    logic                  gnt0, gnt1;
    logic                  rd0, rd1;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    req_id_e               owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_d;
    logic [STRB_W-1:0]     mem_we_d;

    dmem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .req1   (bus.req1),
        .gnt1   (gnt1),
        .force1 (force1)
    );

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            gnt1 = bus.req1 && (!bus.req0 || force1);
            gnt0 = bus.req0 && !gnt1;
        end
    end

    always_comb begin
        mem_addr_d = '0;
        mem_din_d  = '0;
        mem_we_d   = '0;
        if (gnt1) begin
            mem_addr_d = bus.addr1;
            mem_din_d  = bus.wdata1;
            mem_we_d   = bus.wstrb1;
        end else if (gnt0) begin
            mem_addr_d = bus.addr0;
            mem_din_d  = bus.wdata0;
            mem_we_d   = bus.wstrb0;
        end
    end

    assign rd0 = gnt0 && !strb_is_write(STRB_MAX_W'(bus.wstrb0));
    assign rd1 = gnt1 && !strb_is_write(STRB_MAX_W'(bus.wstrb1));

    always_comb begin
        rvalid0_d = rd0;
        rvalid1_d = rd1;
        owner_d   = owner_q;
        if (rd1) begin
            owner_d = REQ_DBG;
        end else if (rd0) begin
            owner_d = REQ_CPU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            owner_q   <= REQ_CPU;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.mem_en   = gnt0 || gnt1;
    assign bus.mem_we   = mem_we_d;
    assign bus.mem_addr = mem_addr_d;
    assign bus.mem_din  = mem_din_d;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = (rvalid0_q && owner_q == REQ_CPU) ? bus.mem_dout : '0;
    assign bus.rdata1   = (rvalid1_q && owner_q == REQ_DBG) ? bus.mem_dout : '0;

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_gnt0_q, perf_gnt0_d;
    logic [31:0] perf_gnt1_q, perf_gnt1_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_gnt0_d     = perf_gnt0_q + {31'd0, gnt0};
        perf_gnt1_d     = perf_gnt1_q + {31'd0, gnt1};
        perf_conflict_d = perf_conflict_q + {31'd0, bus.req0 & bus.req1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_gnt0_q     <= '0;
            perf_gnt1_q     <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_gnt0_q     <= perf_gnt0_d;
            perf_gnt1_q     <= perf_gnt1_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_gnt0     = perf_gnt0_q;
    assign perf_gnt1     = perf_gnt1_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic against a reference model.
module tb_dmem_arbiter;

    localparam int AW       = 14;
    localparam int DW       = 32;
    localparam int SW       = DW / 8;
    localparam int MAX_WAIT = 4;
    localparam int NW       = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef DMEM_ARB_PERF_CNT_EN
        .perf_gnt0     (perf_gnt0),
        .perf_gnt1     (perf_gnt1),
        .perf_conflict (perf_conflict),
`endif
        .bus           (bus)
    );

    function automatic logic [DW-1:0] seed_word(input int i);
        if (i == 16) return 32'h1234_5678;
        if (i == 5)  return 32'h1122_3344;
        return 32'hC0DE_0000 | 32'(i << 8) | 32'(i ^ 8'hFF);
    endfunction

    // Block RAM stand-in: 1-cycle read latency, byte-lane writes.
    logic [DW-1:0] ram [NW];
    logic          ram_load;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NW; i++) ram[i] <= seed_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we == '0) begin
                bus.mem_dout <= ram[bus.mem_addr[5:0]];
            end else begin
                for (int k = 0; k < SW; k++)
                    if (bus.mem_we[k]) ram[bus.mem_addr[5:0]][8*k +: 8] <= bus.mem_din[8*k +: 8];
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [NW];
    int            lost;
    bit            exp_rv0, exp_rv1;
    logic [DW-1:0] exp_rd;
    int unsigned   m_pg0, m_pg1, m_pc;
    bit            last_e0, last_e1, obs_g1;
    int            total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive0(input bit r, input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req0 = r; bus.addr0 = AW'(a); bus.wdata0 = d; bus.wstrb0 = s;
    endtask

    task automatic drive1(input bit r, input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.req1 = r; bus.addr1 = AW'(a); bus.wdata1 = d; bus.wstrb1 = s;
    endtask

    task automatic access(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (s == '0) begin
            exp_rd = ref_mem[a[5:0]];
        end else begin
            for (int k = 0; k < SW; k++)
                if (s[k]) ref_mem[a[5:0]][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
    task automatic cycle(input bit pull_rst);
        bit e0, e1;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (rst_n) begin
            e1 = bus.req1 && (!bus.req0 || lost >= MAX_WAIT);
            e0 = bus.req0 && !e1;
        end
        chk("gnt0", bus.gnt0, e0);
        chk("gnt1", bus.gnt1, e1);
        chk("mem_en", bus.mem_en, e0 || e1);
        if (e1) begin
            chk("mem_addr1", bus.mem_addr, bus.addr1);
            chk("mem_we1", bus.mem_we, bus.wstrb1);
            chk("mem_din1", bus.mem_din, bus.wdata1);
        end else if (e0) begin
            chk("mem_addr0", bus.mem_addr, bus.addr0);
            chk("mem_we0", bus.mem_we, bus.wstrb0);
            chk("mem_din0", bus.mem_din, bus.wdata0);
        end else begin
            chk("idle_addr", bus.mem_addr, 0);
            chk("idle_we", bus.mem_we, 0);
        end
        chk("rvalid0", bus.rvalid0, exp_rv0);
        chk("rvalid1", bus.rvalid1, exp_rv1);
        chk("rdata0", bus.rdata0, exp_rv0 ? exp_rd : 32'd0);
        chk("rdata1", bus.rdata1, exp_rv1 ? exp_rd : 32'd0);
        obs_g1 = bus.gnt1;

        exp_rv0 = e0 && (bus.wstrb0 == '0);
        exp_rv1 = e1 && (bus.wstrb1 == '0);
        if (e0) access(bus.addr0, bus.wdata0, bus.wstrb0);
        if (e1) access(bus.addr1, bus.wdata1, bus.wstrb1);
        if (rst_n) begin
            m_pg0 += 32'(e0);
            m_pg1 += 32'(e1);
            if (bus.req0 && bus.req1) m_pc++;
        end
        lost = (rst_n && bus.req1 && !e1) ? ((lost < MAX_WAIT) ? lost + 1 : lost) : 0;
        last_e0 = e0;
        last_e1 = e1;
        if (pull_rst) rst_n = 1'b0;
        if (!rst_n) begin
            exp_rv0 = 1'b0; exp_rv1 = 1'b0; lost = 0;
            m_pg0 = 0; m_pg1 = 0; m_pc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_strb();
        if ($urandom_range(0, 1) == 0) return '0;
        return SW'($urandom_range(1, (1 << SW) - 1));
    endfunction

    initial begin
        logic [11:0] seq;
        total = 0; bad = 0; lost = 0;
        exp_rv0 = 0; exp_rv1 = 0; exp_rd = '0;
        m_pg0 = 0; m_pg1 = 0; m_pc = 0;
        last_e0 = 0; last_e1 = 0; obs_g1 = 0;
        for (int i = 0; i < NW; i++) ref_mem[i] = seed_word(i);

        // Reset held with both requesting, then straight into the starvation run
        ram_load = 1'b1;
        drive0(1, 16, '0, '0);
        drive1(1, 17, '0, '0);
        cycle(0);
        ram_load = 1'b0;
        cycle(0);
        rst_n = 1'b1;
        seq = '0;
        for (int i = 0; i < 12; i++) begin
            cycle(0);
            seq[i] = obs_g1;
        end
        chk("starve_seq", seq, 12'h210);
`ifdef DMEM_ARB_PERF_CNT_EN
        chk("perf_gnt0_starve", perf_gnt0, 10);
        chk("perf_gnt1_starve", perf_gnt1, 2);
        chk("perf_conflict_starve", perf_conflict, 12);
`endif

        // Single CPU read of 0x10
        drive1(0, 0, '0, '0);
        drive0(1, 16, '0, '0);
        cycle(0);
        chk("single_rv0", bus.rvalid0, 1);
        chk("single_rd0", bus.rdata0, 32'h1234_5678);
        chk("single_rv1", bus.rvalid1, 0);
        drive0(0, 0, '0, '0);
        cycle(0);
        chk("single_rv0_drop", bus.rvalid0, 0);

        // Partial write then read-back from the debug port
        drive1(1, 5, 32'hAABB_CCDD, 4'b0011);
        cycle(0);
        drive1(1, 5, '0, '0);
        cycle(0);
        chk("pw_rv1", bus.rvalid1, 1);
        chk("pw_rd1", bus.rdata1, 32'h1122_CCDD);
        chk("pw_rd0", bus.rdata0, 0);
        drive1(0, 0, '0, '0);
        cycle(0);

        // Reset asserted after a read grant but before its edge
        drive0(1, 9, '0, '0);
        drive1(1, 7, '0, '0);
        cycle(0);
        cycle(0);
        cycle(1);
        chk("rst_mid_rv0", bus.rvalid0, 0);
        chk("rst_mid_wait", dut.u_starve.wait_cnt_q, 0);
        cycle(0);
        rst_n = 1'b1;
        drive0(0, 0, '0, '0);
        drive1(0, 0, '0, '0);
        cycle(0);
        chk("rst_after_rv0", bus.rvalid0, 0);

        // Random traffic; a requester keeps its fields until its grant edge
        for (int n = 0; n < 1500; n++) begin
            if (!bus.req0 || last_e0) begin
                if ($urandom_range(0, 9) < 7) drive0(1, int'($urandom_range(0, NW - 1)), $urandom, rand_strb());
                else                          drive0(0, 0, '0, '0);
            end
            if (!bus.req1 || last_e1) begin
                if ($urandom_range(0, 9) < 6) drive1(1, int'($urandom_range(0, NW - 1)), $urandom, rand_strb());
                else                          drive1(0, 0, '0, '0);
            end
            cycle(0);
        end
`ifdef DMEM_ARB_PERF_CNT_EN
        chk("perf_gnt0_rand", perf_gnt0, m_pg0);
        chk("perf_gnt1_rand", perf_gnt1, m_pg1);
        chk("perf_conflict_rand", perf_conflict, m_pc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
